// File: rtl/joker_ts_pkg.sv
// Shared MPEG-TS constants, FSM encoding and helpers for the serial TS blocks.
// Pure declarations: no latency and no flow control.
package joker_ts_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_SHIFT = 2'd1,
    TS_STALL = 2'd2,
    TS_GAP   = 2'd3
  } ts_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ts_clk_gen.sv
// Free-running ts_clk divider: half-period of CLK_DIV clk cycles, plus a strobe
// valid in the cycle whose closing clk edge drives ts_clk 1->0; no backpressure.
module ts_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic ts_clk,
  output logic fall
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          term;

  assign term = (div_cnt == TERM);
  assign fall = term & ts_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      ts_clk  <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      ts_clk  <= ~ts_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ts_serial_tx.sv
// Serial MPEG-TS transmitter: 188-byte packets out MSB first on ts_clk falls.
// One-byte holding register; in_ready drops while it is full or when disabled.
module ts_serial_tx
  import joker_ts_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_BITS   = 8,
  parameter bit START_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ts_clk,
  output logic        ts_data,
  output logic        ts_valid,
  output logic        ts_start,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  underrun_cnt,
  output logic [7:0]  trunc_cnt
);

  localparam logic [15:0] GAP_LEN   = 16'(GAP_BITS);
  localparam logic [7:0]  LAST_BYTE = 8'(TS_PKT_LEN - 1);

  logic        fall;
  logic        hold_full;
  logic        hold_sop;
  logic [7:0]  hold_data;
  logic        accept;
  logic        consume;

  ts_state_e   state;
  ts_state_e   state_nxt;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [15:0] gap_cnt;

  logic do_start, do_next, do_shift, do_quiet, do_drop;
  logic do_pkt, do_trunc, do_under, do_gap_init, do_gap_inc;
  logic idle_eval, boundary;
  logic data_nxt, valid_nxt, start_nxt;

  ts_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .ts_clk  (ts_clk),
    .fall    (fall)
  );

  assign in_ready = enable & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign consume  = do_start | do_next | do_drop;

  // accept only happens while empty and consume only while full, so they never collide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_sop  <= 1'b0;
      hold_data <= 8'h00;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_sop  <= in_sop;
      hold_data <= in_data;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= TS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_start    = 1'b0;
    do_next     = 1'b0;
    do_shift    = 1'b0;
    do_quiet    = 1'b0;
    do_drop     = 1'b0;
    do_pkt      = 1'b0;
    do_trunc    = 1'b0;
    do_under    = 1'b0;
    do_gap_init = 1'b0;
    do_gap_inc  = 1'b0;
    idle_eval   = 1'b0;
    boundary    = 1'b0;
    if (fall) begin
      case (state)
        TS_IDLE: idle_eval = 1'b1;
        TS_GAP: begin
          if (gap_cnt >= GAP_LEN) idle_eval  = 1'b1;
          else                    do_gap_inc = 1'b1;
        end
        TS_SHIFT: begin
          if (bit_cnt != 3'd7) begin
            do_shift = 1'b1;
          end else if (byte_cnt == LAST_BYTE) begin
            do_pkt   = 1'b1;
            do_quiet = 1'b1;
            if (GAP_BITS == 0) begin
              idle_eval = 1'b1;
            end else begin
              state_nxt   = TS_GAP;
              do_gap_init = 1'b1;
            end
          end else begin
            boundary = 1'b1;
          end
        end
        TS_STALL: boundary = 1'b1;
        default:  state_nxt = TS_IDLE;
      endcase
    end
    if (boundary) begin
      if (hold_full && !hold_sop) begin
        do_next   = 1'b1;
        state_nxt = TS_SHIFT;
      end else if (hold_full) begin
        do_trunc  = 1'b1;
        idle_eval = 1'b1;
      end else if (state == TS_SHIFT) begin
        do_under  = 1'b1;
        do_quiet  = 1'b1;
        state_nxt = TS_STALL;
      end
    end
    // shared by IDLE, end of gap, zero-gap packet end and early-SOP truncation
    if (idle_eval) begin
      if (hold_full && hold_sop && enable) begin
        do_start  = 1'b1;
        do_quiet  = 1'b0;
        state_nxt = TS_SHIFT;
      end else begin
        do_quiet  = 1'b1;
        do_drop   = hold_full & ~hold_sop;
        state_nxt = TS_IDLE;
      end
    end
  end

  always_comb begin
    data_nxt  = ts_data;
    valid_nxt = ts_valid;
    start_nxt = ts_start;
    if (do_start || do_next) begin
      data_nxt  = hold_data[7];
      valid_nxt = 1'b1;
      start_nxt = do_start;
    end else if (do_shift) begin
      data_nxt  = shreg[6];
      valid_nxt = 1'b1;
      start_nxt = START_FULL && (byte_cnt == 8'd0);
    end else if (do_quiet) begin
      data_nxt  = 1'b0;
      valid_nxt = 1'b0;
      start_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_data      <= 1'b0;
      ts_valid     <= 1'b0;
      ts_start     <= 1'b0;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      byte_cnt     <= 8'd0;
      gap_cnt      <= 16'd0;
      pkt_cnt      <= 16'd0;
      drop_cnt     <= 8'd0;
      underrun_cnt <= 8'd0;
      trunc_cnt    <= 8'd0;
    end else begin
      ts_data  <= data_nxt;
      ts_valid <= valid_nxt;
      ts_start <= start_nxt;
      if (do_start || do_next) begin
        shreg   <= hold_data;
        bit_cnt <= 3'd0;
      end else if (do_shift) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (do_start)     byte_cnt <= 8'd0;
      else if (do_next) byte_cnt <= byte_cnt + 8'd1;
      // the fall that ends the packet is already the first idle bit period
      if (do_gap_init)     gap_cnt <= 16'd1;
      else if (do_gap_inc) gap_cnt <= gap_cnt + 16'd1;
      if (do_pkt)   pkt_cnt      <= pkt_cnt + 16'd1;
      if (do_drop)  drop_cnt     <= sat_inc8(drop_cnt);
      if (do_under) underrun_cnt <= sat_inc8(underrun_cnt);
      if (do_trunc) trunc_cnt    <= sat_inc8(trunc_cnt);
    end
  end

endmodule

// File: tb/tb_ts_serial_tx.sv
// Directed bench for ts_serial_tx: drives packets, decodes the serial bus on
// ts_clk rises and scores bytes, start flags, gaps and counters.
module tb_ts_serial_tx;

  localparam int CLK_DIV    = 2;
  localparam int GAP_BITS   = 8;
  localparam bit START_FULL = 1'b1;
  localparam int BIT_CLKS   = 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_valid;
  logic        in_ready;
  logic        ts_clk, ts_data, ts_valid, ts_start;
  logic [15:0] pkt_cnt;
  logic [7:0]  drop_cnt, underrun_cnt, trunc_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] expq[$];
  logic [15:0] exp_item;
  int          valid_bits = 0;
  int          inv_run = 0;
  int          last_gap = -1;
  int          idle_bad = 0;
  int          acc_n = 0;
  logic [7:0]  acc, smask;
  logic        ts_clk_q = 1'b0;
  int          vb0;

  always #5 clk = ~clk;

  ts_serial_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS), .START_FULL(START_FULL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ts_clk       (ts_clk),
    .ts_data      (ts_data),
    .ts_valid     (ts_valid),
    .ts_start     (ts_start),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .underrun_cnt (underrun_cnt),
    .trunc_cnt    (trunc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int i, input logic [7:0] seed);
    if (i == 0) return 8'h47;
    return 8'(i - 1) + seed;
  endfunction

  // receiver model: sample on each ts_clk rise, assemble MSB-first bytes
  always @(negedge clk) begin
    if (!reset_n) begin
      acc_n = 0;
    end else if (ts_clk && !ts_clk_q) begin
      if (ts_valid) begin
        if (acc_n == 0 && ts_start) last_gap = inv_run;
        inv_run = 0;
        valid_bits++;
        acc   = {acc[6:0], ts_data};
        smask = {smask[6:0], ts_start};
        acc_n++;
        if (acc_n == 8) begin
          acc_n = 0;
          chk("scoreboard_nonempty", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) begin
            exp_item = expq.pop_front();
            chk("rx_byte", {24'd0, acc}, {24'd0, exp_item[7:0]});
            chk("rx_start_mask", {24'd0, smask}, {24'd0, exp_item[15:8]});
          end
        end
      end else begin
        inv_run++;
        if (ts_data !== 1'b0) idle_bad++;
      end
    end
    ts_clk_q = ts_clk;
  end

  task automatic send_byte(input logic [7:0] b, input logic sop, input logic exp_tx);
    int n = 0;
    if (exp_tx) expq.push_back({(sop ? 8'hFF : 8'h00), b});
    in_data  = b;
    in_sop   = sop;
    in_valid = 1'b1;
    while (!in_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] seed, input int first, input int last, input int pause_at);
    for (int i = first; i <= last; i++) begin
      send_byte(pbyte(i, seed), (i == 0), 1'b1);
      if (i == pause_at) repeat (20 * BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic wait_pkts(input logic [15:0] target);
    int n = 0;
    while (pkt_cnt !== target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, target});
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    in_data  = 8'h00;
    in_sop   = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ts_valid", {31'd0, ts_valid}, 32'd0);
    chk("rst_ts_clk", {31'd0, ts_clk}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    reset_n = 1'b1;

    // 1: single packet 47,00..BA
    vb0 = valid_bits;
    send_range(8'h00, 0, 187, -1);
    wait_pkts(16'd1);
    chk("t1_valid_bits", valid_bits - vb0, 32'd1504);
    chk("t1_queue_empty", expq.size(), 32'd0);

    // 2: two back-to-back packets separated by exactly GAP_BITS idle bits
    vb0 = valid_bits;
    send_range(8'h10, 0, 187, -1);
    send_range(8'h20, 0, 187, -1);
    wait_pkts(16'd3);
    chk("t2_gap_bits", last_gap, GAP_BITS);
    chk("t2_valid_bits", valid_bits - vb0, 32'd3008);

    // 3: starvation after byte 10
    vb0 = valid_bits;
    send_range(8'h30, 0, 10, 10);
    chk("t3_stall_valid", {31'd0, ts_valid}, 32'd0);
    chk("t3_stall_data", {31'd0, ts_data}, 32'd0);
    chk("t3_underrun", {24'd0, underrun_cnt}, 32'd1);
    send_range(8'h30, 11, 187, -1);
    wait_pkts(16'd4);
    chk("t3_valid_bits", valid_bits - vb0, 32'd1504);
    chk("t3_underrun_end", {24'd0, underrun_cnt}, 32'd1);

    // 4: three stray bytes before SOP are dropped
    vb0 = valid_bits;
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    send_range(8'h40, 0, 187, -1);
    wait_pkts(16'd5);
    chk("t4_drop_cnt", {24'd0, drop_cnt}, 32'd3);
    chk("t4_valid_bits", valid_bits - vb0, 32'd1504);

    // 5: SOP arrives at byte 100 of a packet
    vb0 = valid_bits;
    send_range(8'h50, 0, 99, -1);
    send_range(8'h60, 0, 187, -1);
    wait_pkts(16'd6);
    chk("t5_trunc_cnt", {24'd0, trunc_cnt}, 32'd1);
    chk("t5_restart_gap", last_gap, 32'd0);
    chk("t5_valid_bits", valid_bits - vb0, 32'd2304);
    chk("t5_queue_empty", expq.size(), 32'd0);
    chk("idle_data_zero", idle_bad, 32'd0);

    // 6: async reset at byte 50
    send_range(8'h70, 0, 49, -1);
    reset_n = 1'b0;
    #1;
    chk("t6_ts_valid", {31'd0, ts_valid}, 32'd0);
    chk("t6_ts_data", {31'd0, ts_data}, 32'd0);
    chk("t6_ts_start", {31'd0, ts_start}, 32'd0);
    chk("t6_ts_clk", {31'd0, ts_clk}, 32'd0);
    chk("t6_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("t6_trunc_cnt", {24'd0, trunc_cnt}, 32'd0);
    chk("t6_underrun", {24'd0, underrun_cnt}, 32'd0);
    chk("t6_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    expq.delete();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    vb0 = valid_bits;
    repeat (100 * BIT_CLKS) @(negedge clk);
    chk("t6_no_tx", valid_bits - vb0, 32'd0);
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (4 * BIT_CLKS) @(negedge clk);
    chk("t6_drop_after_rst", {24'd0, drop_cnt}, 32'd1);
    chk("t6_no_tx_after_drop", valid_bits - vb0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
